// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - ID-stage forwarding select, load-use stall and stall counter
module pipe_hazard_ctrl #(
  parameter int REG_ADDRESS_LENGTH = 5,
  parameter int FWD_DEPTH          = 2,
  parameter bit ZERO_REG_HARDWIRED = 1'b1,
  parameter int CNT_WIDTH          = 16,
  localparam int SEL_W             = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [REG_ADDRESS_LENGTH-1:0] id_ra,
  input  logic [REG_ADDRESS_LENGTH-1:0] id_rb,
  input  logic                          id_ra_used,
  input  logic                          id_rb_used,
  input  logic                          id_wr_en,
  input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
  input  logic                          id_is_load,
  input  logic                          flush,
  output logic [SEL_W-1:0]              sel_ra,
  output logic [SEL_W-1:0]              sel_rb,
  output logic                          stall,
  output logic [CNT_WIDTH-1:0]          stall_count
);

  // In-flight destinations: entry 0 is EX/MEM, entry FWD_DEPTH-1 is WB.
  logic [FWD_DEPTH-1:0]          ent_v;
  logic [REG_ADDRESS_LENGTH-1:0] ent_rd [FWD_DEPTH];
  // Load flag is only consulted while the load sits in entry 0; from entry 1
  // onward its data is ready, so older entries do not need to carry it.
  logic                          ent0_ld;

  logic ra_ok;
  logic rb_ok;
  logic ra_hit0;
  logic rb_hit0;

  // Source qualification: operand must be read by a real instruction, r0 optionally excluded.
  always_comb begin
    ra_ok = id_valid & id_ra_used & ~(ZERO_REG_HARDWIRED && (id_ra == '0));
    rb_ok = id_valid & id_rb_used & ~(ZERO_REG_HARDWIRED && (id_rb == '0));
  end

  // Forwarding selects: scan oldest to youngest so the youngest match is the last write.
  always_comb begin
    sel_ra = '0;
    sel_rb = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (ra_ok && ent_v[k] && (ent_rd[k] == id_ra)) sel_ra = SEL_W'(k + 1);
      if (rb_ok && ent_v[k] && (ent_rd[k] == id_rb)) sel_rb = SEL_W'(k + 1);
    end
  end

  // Load-use stall: youngest match in entry 0 holding a load; a flush always wins.
  always_comb begin
    ra_hit0 = ra_ok & ent_v[0] & (ent_rd[0] == id_ra);
    rb_hit0 = rb_ok & ent_v[0] & (ent_rd[0] == id_rb);
    stall   = ~flush & ent0_ld & (ra_hit0 | rb_hit0);
  end

  // Destination shift register: advances every cycle, stall/flush only bubble entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_v   <= '0;
      ent0_ld <= 1'b0;
      for (int k = 0; k < FWD_DEPTH; k++) ent_rd[k] <= '0;
    end else begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        ent_v[k]  <= ent_v[k-1];
        ent_rd[k] <= ent_rd[k-1];
      end
      ent_v[0]  <= id_valid & id_wr_en & ~stall & ~flush;
      ent_rd[0] <= id_rd;
      ent0_ld   <= id_is_load;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed-vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_ra;
  logic [4:0] id_rb;
  logic       id_ra_used;
  logic       id_rb_used;
  logic       id_wr_en;
  logic [4:0] id_rd;
  logic       id_is_load;
  logic       flush;
  logic [1:0] sel_ra;
  logic [1:0] sel_rb;
  logic       stall;
  logic [3:0] stall_count;

  int n_vec  = 0;
  int n_miss = 0;

  pipe_hazard_ctrl #(
    .REG_ADDRESS_LENGTH(5),
    .FWD_DEPTH(2),
    .ZERO_REG_HARDWIRED(1'b1),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .id_ra(id_ra),
    .id_rb(id_rb),
    .id_ra_used(id_ra_used),
    .id_rb_used(id_rb_used),
    .id_wr_en(id_wr_en),
    .id_rd(id_rd),
    .id_is_load(id_is_load),
    .flush(flush),
    .sel_ra(sel_ra),
    .sel_rb(sel_rb),
    .stall(stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] ra, input logic rau,
                        input logic [4:0] rb, input logic rbu, input logic wr,
                        input logic [4:0] rd, input logic ld, input logic fl);
    id_valid   = v;
    id_ra      = ra;
    id_ra_used = rau;
    id_rb      = rb;
    id_rb_used = rbu;
    id_wr_en   = wr;
    id_rd      = rd;
    id_is_load = ld;
    flush      = fl;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // 1: reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_id(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    check("rst_sel_ra", 32'(sel_ra), 0);
    check("rst_sel_rb", 32'(sel_rb), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_count", 32'(stall_count), 0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("post_rst_sel_ra", 32'(sel_ra), 0);
    check("post_rst_stall", 32'(stall), 0);
    tick();

    // 2: back-to-back ALU forwarding
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("alu_sel_ra_e0", 32'(sel_ra), 1);
    check("alu_stall", 32'(stall), 0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("alu_sel_rb_e1", 32'(sel_rb), 2);
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("alu_sel_ra_gone", 32'(sel_ra), 0);
    check("alu_sel_rb_gone", 32'(sel_rb), 0);
    tick();

    // 3: load-use stall, then forward from entry 1
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
    check("ld_stall", 32'(stall), 1);
    check("ld_sel_ra_e0", 32'(sel_ra), 1);
    tick();
    check("ld_stall_released", 32'(stall), 0);
    check("ld_sel_ra_e1", 32'(sel_ra), 2);
    check("ld_count_1", 32'(stall_count), 1);
    tick();
    // the stalled-then-issued instruction writes r6 and must be tracked
    set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("ld_after_sel_r6", 32'(sel_ra), 1);
    tick();

    // 4: priority, used gating, id_valid gating, r0
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("prio_sel_rb_youngest", 32'(sel_rb), 1);
    check("prio_sel_ra_unused", 32'(sel_ra), 0);
    set_id(1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("prio_bubble_sel_rb", 32'(sel_rb), 0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("r0_sel_ra", 32'(sel_ra), 0);
    check("r0_sel_rb", 32'(sel_rb), 0);
    check("r0_no_stall", 32'(stall), 0);
    tick();

    // 5: flush overrides stall and drops the ID instruction
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
    check("flush_stall", 32'(stall), 0);
    check("flush_sel_ra", 32'(sel_ra), 1);
    tick();
    set_id(1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("flush_e1_sel_ra", 32'(sel_ra), 2);
    check("flush_dropped_sel_rb", 32'(sel_rb), 0);
    check("flush_no_stall", 32'(stall), 0);
    check("flush_count", 32'(stall_count), 1);
    tick();

    // 6: saturation of the 4-bit counter
    for (int i = 1; i <= 20; i++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      if (i == 1 || i == 20) check("sat_stall", 32'(stall), 1);
      tick();
      if (i == 1) check("sat_one_stall_only", 32'(stall), 0);
      if (i == 10) check("sat_count_11", 32'(stall_count), 11);
      if (i == 14) check("sat_count_15", 32'(stall_count), 15);
    end
    check("sat_count_hold", 32'(stall_count), 15);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("mid_stall_before_rst", 32'(stall), 1);
    rst = 1'b0;
    #1;
    check("async_rst_stall", 32'(stall), 0);
    check("async_rst_count", 32'(stall_count), 0);
    check("async_rst_sel_ra", 32'(sel_ra), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("after_rst_stall", 32'(stall), 0);
    check("after_rst_count", 32'(stall_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
